// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: blank code, glyph table and position-to-nibble mapping,
// used by both the puzzle encoders and the display driver.
package seg_pkg;

    localparam int unsigned NUM_POS   = 8;
    localparam int unsigned BUS_W     = 4 * NUM_POS;
    localparam int unsigned POS_W     = 3;
    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned PATTERN_W = 8;

    localparam logic [NIBBLE_W-1:0] BLANK_NIBBLE = 4'hF;

    // Active-high {g,f,e,d,c,b,a} per nibble value; F is the blank glyph.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h00
    };

    // Each byte is packed [tens][ones] with the low nibble shown on the left digit.
    function automatic logic [POS_W-1:0] pos_to_nibble(input logic [POS_W-1:0] p);
        return 3'd6 - {p[2:1], 1'b0} + {2'b00, p[0]};
    endfunction

    function automatic logic [NIBBLE_W-1:0] nibble_at(input logic [BUS_W-1:0] bus,
                                                      input logic [POS_W-1:0] p);
        logic [4:0] lsb;
        lsb = {pos_to_nibble(p), 2'b00};
        return bus[lsb +: 4];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to active-high {dp,g,f,e,d,c,b,a} pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0]  nibble,
    input  logic                 dp,
    output logic [PATTERN_W-1:0] pattern_c
);

    always_comb begin
        pattern_c = {dp, SEG_TABLE[nibble]};
    end

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit time-multiplexed 7-segment scanner with per-frame tear-free shadowing,
// guard-band blanking between digits, per-digit decimal point and blink.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 20000,
    parameter int unsigned GUARD          = 200,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter bit          COM_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_W-1:0]     seg_display,
    input  logic [NUM_POS-1:0]   dp_en,
    input  logic [NUM_POS-1:0]   blink_en,
    input  logic                 display_on,
    output logic [NUM_POS-1:0]   seg_com,
    output logic [PATTERN_W-1:0] seg_data,
    output logic                 frame_tick
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0]     FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_POS-1:0]   COM_IDLE = COM_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [PATTERN_W-1:0] SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DIV_W-1:0]     div_cnt,      div_nxt;
    logic [POS_W-1:0]     pos,          pos_nxt;
    logic [FRM_W-1:0]     frm_cnt,      frm_nxt;
    logic                 blink_ph,     blink_ph_nxt;
    logic [BUS_W-1:0]     shadow_disp,  shadow_disp_nxt;
    logic [NUM_POS-1:0]   shadow_dp,    shadow_dp_nxt;
    logic [NUM_POS-1:0]   shadow_blink, shadow_blink_nxt;
    logic [NUM_POS-1:0]   seg_com_nxt;
    logic [PATTERN_W-1:0] seg_data_nxt;
    logic                 frame_tick_nxt;

    logic                 slot_end_c;
    logic                 frame_end_c;
    logic                 lit_c;
    logic                 blank_c;
    logic [NIBBLE_W-1:0]  nibble_c;
    logic [PATTERN_W-1:0] pattern_c;
    logic [NUM_POS-1:0]   com_act_c;
    logic [PATTERN_W-1:0] seg_act_c;

    seg_hex_decode u_decode (
        .nibble    (nibble_c),
        .dp        (shadow_dp[pos]),
        .pattern_c (pattern_c)
    );

    // Scan/shadow/blink state and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            pos          <= '0;
            frm_cnt      <= '0;
            blink_ph     <= 1'b0;
            shadow_disp  <= '1;
            shadow_dp    <= '0;
            shadow_blink <= '0;
            seg_com      <= COM_IDLE;
            seg_data     <= SEG_IDLE;
            frame_tick   <= 1'b0;
        end else begin
            div_cnt      <= div_nxt;
            pos          <= pos_nxt;
            frm_cnt      <= frm_nxt;
            blink_ph     <= blink_ph_nxt;
            shadow_disp  <= shadow_disp_nxt;
            shadow_dp    <= shadow_dp_nxt;
            shadow_blink <= shadow_blink_nxt;
            seg_com      <= seg_com_nxt;
            seg_data     <= seg_data_nxt;
            frame_tick   <= frame_tick_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        div_nxt          = div_cnt + DIV_W'(1);
        pos_nxt          = pos;
        frm_nxt          = frm_cnt;
        blink_ph_nxt     = blink_ph;
        shadow_disp_nxt  = shadow_disp;
        shadow_dp_nxt    = shadow_dp;
        shadow_blink_nxt = shadow_blink;

        slot_end_c  = (div_cnt == DIV_LAST);
        frame_end_c = slot_end_c && (pos == 3'd7);

        if (slot_end_c) begin
            div_nxt = '0;
            pos_nxt = pos + 3'd1;
        end

        if (frame_end_c) begin
            shadow_disp_nxt  = seg_display;
            shadow_dp_nxt    = dp_en;
            shadow_blink_nxt = blink_en;
            if (frm_cnt == FRM_LAST) begin
                frm_nxt      = '0;
                blink_ph_nxt = ~blink_ph;
            end else begin
                frm_nxt = frm_cnt + FRM_W'(1);
            end
        end

        // Blinked digits keep their common asserted but drive no segments.
        nibble_c  = nibble_at(shadow_disp, pos);
        blank_c   = blink_ph && shadow_blink[pos];
        lit_c     = (32'(div_cnt) >= GUARD) && display_on;
        com_act_c = lit_c ? (8'b0000_0001 << pos) : 8'h00;
        seg_act_c = (lit_c && !blank_c) ? pattern_c : 8'h00;

        seg_com_nxt    = COM_ACTIVE_LOW ? ~com_act_c : com_act_c;
        seg_data_nxt   = SEG_ACTIVE_LOW ? ~seg_act_c : seg_act_c;
        frame_tick_nxt = frame_end_c;
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a cycle-index reference model.
module tb_seg_scan_driver;

    localparam int unsigned SD = 8;
    localparam int unsigned GD = 2;
    localparam int unsigned BF = 2;
    localparam int unsigned FRAME = 8 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seg_display = 32'h3412_FF52;
    logic [7:0]  dp_en = 8'h00;
    logic [7:0]  blink_en = 8'h00;
    logic        display_on = 1'b1;
    logic [7:0]  seg_com;
    logic [7:0]  seg_data;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // Model: everything follows from the cycle count since reset release.
    int unsigned t;
    logic [31:0] cur_disp;
    logic [7:0]  cur_dp;
    logic [7:0]  cur_blk;

    seg_scan_driver #(
        .SCAN_DIV       (SD),
        .GUARD          (GD),
        .BLINK_FRAMES   (BF),
        .COM_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_display (seg_display),
        .dp_en       (dp_en),
        .blink_en    (blink_en),
        .display_on  (display_on),
        .seg_com     (seg_com),
        .seg_data    (seg_data),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'h3F;
            4'h1: return 8'h06;
            4'h2: return 8'h5B;
            4'h3: return 8'h4F;
            4'h4: return 8'h66;
            4'h5: return 8'h6D;
            4'h6: return 8'h7D;
            4'h7: return 8'h07;
            4'h8: return 8'h7F;
            4'h9: return 8'h6F;
            4'hA: return 8'h77;
            4'hB: return 8'h7C;
            4'hC: return 8'h39;
            4'hD: return 8'h5E;
            4'hE: return 8'h79;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        t        = 0;
        cur_disp = 32'hFFFF_FFFF;
        cur_dp   = 8'h00;
        cur_blk  = 8'h00;
    endtask

    // Predict the pins for the current cycle's state, advance one clock, compare at negedge.
    task automatic cycle();
        int unsigned div, pos, frame, q;
        logic        ph, lit, blank;
        logic [3:0]  nib;
        logic [7:0]  on_pat, exp_com, exp_seg;
        logic        exp_ft;
        div    = t % SD;
        pos    = (t / SD) % 8;
        frame  = t / FRAME;
        ph     = ((frame / BF) % 2) == 1;
        lit    = (div >= GD) && display_on;
        q      = 6 - 2 * (pos / 2) + (pos % 2);
        nib    = cur_disp[4*q +: 4];
        blank  = ph && cur_blk[pos];
        on_pat = glyph(nib) | (cur_dp[pos] ? 8'h80 : 8'h00);
        exp_com = lit ? ~(8'h01 << pos) : 8'hFF;
        exp_seg = (lit && !blank) ? ~on_pat : 8'hFF;
        exp_ft  = (div == SD - 1) && (pos == 7);
        if (exp_ft) begin
            cur_disp = seg_display;
            cur_dp   = dp_en;
            cur_blk  = blink_en;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
        check("seg_com", 32'(seg_com), 32'(exp_com));
        check("seg_data", 32'(seg_data), 32'(exp_seg));
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_com"}, 32'(seg_com), 32'hFF);
        check({tag, "_seg"}, 32'(seg_data), 32'hFF);
        check({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    task automatic rand_inputs();
        if ($urandom_range(0, 15) == 0) seg_display = $urandom;
        if ($urandom_range(0, 31) == 0) dp_en = 8'($urandom);
        if ($urandom_range(0, 31) == 0) blink_en = 8'($urandom);
        if ($urandom_range(0, 99) == 0) display_on = ~display_on;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // First frame blank, then the test pattern.
        repeat (3 * FRAME) cycle();

        // New value mid-frame at pos 3 must wait for the next frame boundary.
        while (t % FRAME != 3 * SD + 1) cycle();
        seg_display = 32'h9876_5410;
        repeat (2 * FRAME) cycle();
        seg_display = 32'hEDCB_A0F1;

        // Decimal point and blink across several blink half-periods.
        dp_en    = 8'h01;
        blink_en = 8'h80;
        repeat (7 * FRAME) cycle();

        // Display off for 20 cycles; counters keep running.
        display_on = 1'b0;
        repeat (20) cycle();
        display_on = 1'b1;
        repeat (2 * FRAME) cycle();

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            rand_inputs();
            cycle();
        end
        display_on = 1'b1;

        // Async reset at pos 5, div 4.
        while (t % FRAME != 5 * SD + 4) cycle();
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        repeat (3) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        model_reset();
        seg_display = $urandom;
        rst_n = 1'b1;
        repeat (FRAME + 5) cycle();
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
